// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared types and constants for the multicycle control unit
//
// Purpose: FSM state encoding, instruction-class enum, RV64 opcode/funct3
// constants and immediate-format codes used by control_unit and instr_decoder.
// Ports: none (package).
package control_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_LOAD    = 3'd0,
    CLS_STORE   = 3'd1,
    CLS_OP      = 3'd2,
    CLS_OPIMM   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_ILLEGAL = 3'd5
  } instr_class_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Immediate format the datapath must build for a given class.
  function automatic logic [1:0] imm_for_class(input instr_class_t cls);
    case (cls)
      CLS_STORE:  return IMM_S;
      CLS_BRANCH: return IMM_B;
      default:    return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control bus between control_unit and the datapath
//
// Purpose: bundles the instruction/flag inputs and every datapath control line.
// Signals:
//   instr, zero            : datapath -> control (IR contents, ULA zero flag)
//   load_ir, imm_sel       : IR load enable, immediate format (00 I, 01 S, 10 B)
//   sub, ULA_din2_sel      : ULA subtract, ULA operand 2 select (1 = imm)
//   RF_din_sel             : register-file data select (1 = ULA, 0 = memory)
//   WE_RF, WE_MEM          : register-file / data-memory write enables
//   load_pc, reset_pc      : PC update enable, active-low PC clear
//   pc_next_sel            : 1 = PC + branch offset, 0 = PC + 4
// Modports: master = control unit side, slave = datapath side.
interface control_unit_if;

  logic [31:0] instr;
  logic        zero;
  logic        load_ir;
  logic [1:0]  imm_sel;
  logic        sub;
  logic        ULA_din2_sel;
  logic        RF_din_sel;
  logic        WE_RF;
  logic        WE_MEM;
  logic        load_pc;
  logic        reset_pc;
  logic        pc_next_sel;

  modport master (
    input  instr, zero,
    output load_ir, imm_sel, sub, ULA_din2_sel, RF_din_sel,
           WE_RF, WE_MEM, load_pc, reset_pc, pc_next_sel
  );

  modport slave (
    output instr, zero,
    input  load_ir, imm_sel, sub, ULA_din2_sel, RF_din_sel,
           WE_RF, WE_MEM, load_pc, reset_pc, pc_next_sel
  );

endinterface

// File: rtl/control_unit_instr_decoder.sv
// rtl/control_unit_instr_decoder.sv - combinational instruction class decoder
//
// Purpose: maps the opcode/funct3/bit-30 fields of an instruction to a class.
// Ports:
//   opcode  in  7 : instr[6:0]
//   funct3  in  3 : instr[14:12]
//   bit30   in  1 : instr[30] (add/sub select for OP)
//   cls     out   : decoded instruction class
//   is_sub  out 1 : OP class with bit30 set
//   is_bne  out 1 : BRANCH class with funct3 = bne
module instr_decoder
  import control_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         bit30,
  output instr_class_t cls,
  output logic         is_sub,
  output logic         is_bne
);

  always_comb begin
    cls    = CLS_ILLEGAL;
    is_sub = 1'b0;
    is_bne = 1'b0;
    case (opcode)
      OPC_LOAD:  cls = CLS_LOAD;
      OPC_STORE: cls = CLS_STORE;
      OPC_OP: begin
        if (funct3 == F3_ADD) begin
          cls    = CLS_OP;
          is_sub = bit30;
        end
      end
      OPC_OPIMM: begin
        if (funct3 == F3_ADD) cls = CLS_OPIMM;
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          cls    = CLS_BRANCH;
          is_bne = (funct3 == F3_BNE);
        end
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle control FSM for the RV64 load-store datapath
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB, drives all datapath controls,
// counts retired instructions and halts stickily on illegal opcodes.
// Ports:
//   CLK      in        : clock, rising edge
//   reset    in        : synchronous active-high reset
//   bus      master    : control_unit_if (instr/zero in, datapath controls out)
//   halted   out 1     : high while in HALT
//   retired  out CNT_W : completed-instruction count, wraps
module control_unit
  import control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             reset,
  control_unit_if.master   bus,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t       state, state_next;
  instr_class_t cls_q, cls_dec;
  logic         is_sub_q, is_bne_q;
  logic         is_sub_dec, is_bne_dec;
  logic         retire;
  logic         alu_din2;
  logic         alu_sub;

  instr_decoder u_decoder (
    .opcode (bus.instr[6:0]),
    .funct3 (bus.instr[14:12]),
    .bit30  (bus.instr[30]),
    .cls    (cls_dec),
    .is_sub (is_sub_dec),
    .is_bne (is_bne_dec)
  );

  // instr is only looked at in DECODE; the latched class drives everything after.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= ST_INIT;
      cls_q    <= CLS_ILLEGAL;
      is_sub_q <= 1'b0;
      is_bne_q <= 1'b0;
      retired  <= '0;
    end else begin
      state <= state_next;
      if (state == ST_DECODE) begin
        cls_q    <= cls_dec;
        is_sub_q <= is_sub_dec;
        is_bne_q <= is_bne_dec;
      end
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // ULA controls are held constant from EXEC through the last state.
  always_comb begin
    alu_din2 = (cls_q == CLS_LOAD) || (cls_q == CLS_STORE) || (cls_q == CLS_OPIMM);
    if (cls_q == CLS_OP)          alu_sub = is_sub_q;
    else if (cls_q == CLS_BRANCH) alu_sub = 1'b1;
    else                          alu_sub = 1'b0;
  end

  always_comb begin
    state_next       = state;
    retire           = 1'b0;
    halted           = 1'b0;
    bus.load_ir      = 1'b0;
    bus.imm_sel      = IMM_I;
    bus.sub          = 1'b0;
    bus.ULA_din2_sel = 1'b0;
    bus.RF_din_sel   = 1'b0;
    bus.WE_RF        = 1'b0;
    bus.WE_MEM       = 1'b0;
    bus.load_pc      = 1'b0;
    bus.reset_pc     = 1'b1;
    bus.pc_next_sel  = 1'b0;

    case (state)
      ST_INIT: begin
        bus.reset_pc = 1'b0;
        state_next   = ST_FETCH;
      end

      ST_FETCH: begin
        bus.load_ir = 1'b1;
        state_next  = ST_DECODE;
      end

      ST_DECODE: begin
        state_next = (cls_dec == CLS_ILLEGAL) ? ST_HALT : ST_EXEC;
      end

      ST_EXEC: begin
        bus.imm_sel      = imm_for_class(cls_q);
        bus.ULA_din2_sel = alu_din2;
        bus.sub          = alu_sub;
        case (cls_q)
          CLS_BRANCH: begin
            // Only Mealy path: zero is the live compare result this cycle.
            bus.load_pc     = 1'b1;
            bus.pc_next_sel = bus.zero ^ is_bne_q;
            retire          = 1'b1;
            state_next      = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_next = ST_MEM;
          default:             state_next = ST_WB;
        endcase
      end

      ST_MEM: begin
        bus.imm_sel      = imm_for_class(cls_q);
        bus.ULA_din2_sel = alu_din2;
        bus.sub          = alu_sub;
        if (cls_q == CLS_STORE) begin
          bus.WE_MEM  = 1'b1;
          bus.load_pc = 1'b1;
          retire      = 1'b1;
          state_next  = ST_FETCH;
        end else begin
          state_next = ST_WB;
        end
      end

      ST_WB: begin
        bus.imm_sel      = imm_for_class(cls_q);
        bus.ULA_din2_sel = alu_din2;
        bus.sub          = alu_sub;
        bus.WE_RF        = 1'b1;
        bus.RF_din_sel   = (cls_q != CLS_LOAD);
        bus.load_pc      = 1'b1;
        retire           = 1'b1;
        state_next       = ST_FETCH;
      end

      ST_HALT: begin
        halted     = 1'b1;
        state_next = ST_HALT;
      end

      default: state_next = ST_INIT;
    endcase

    // Reset wins combinationally so a reset landing mid-instruction never lets
    // a write enable or PC update escape in that cycle.
    if (reset) begin
      retire           = 1'b0;
      halted           = 1'b0;
      bus.load_ir      = 1'b0;
      bus.imm_sel      = IMM_I;
      bus.sub          = 1'b0;
      bus.ULA_din2_sel = 1'b0;
      bus.RF_din_sel   = 1'b0;
      bus.WE_RF        = 1'b0;
      bus.WE_MEM       = 1'b0;
      bus.load_pc      = 1'b0;
      bus.reset_pc     = 1'b0;
      bus.pc_next_sel  = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

  // Packed control vector:
  // {load_ir, imm_sel[1:0], sub, din2, rf_din, we_rf, we_mem, load_pc, reset_pc, pc_next_sel, halted}
  localparam logic [11:0] V_RST     = 12'b0_00_0_0_0_0_0_0_0_0_0;
  localparam logic [11:0] V_FETCH   = 12'b1_00_0_0_0_0_0_0_1_0_0;
  localparam logic [11:0] V_DEC     = 12'b0_00_0_0_0_0_0_0_1_0_0;
  localparam logic [11:0] V_LD_EX   = 12'b0_00_0_1_0_0_0_0_1_0_0;
  localparam logic [11:0] V_LD_WB   = 12'b0_00_0_1_0_1_0_1_1_0_0;
  localparam logic [11:0] V_SUB_EX  = 12'b0_00_1_0_0_0_0_0_1_0_0;
  localparam logic [11:0] V_SUB_WB  = 12'b0_00_1_0_1_1_0_1_1_0_0;
  localparam logic [11:0] V_SD_EX   = 12'b0_01_0_1_0_0_0_0_1_0_0;
  localparam logic [11:0] V_SD_MEM  = 12'b0_01_0_1_0_0_1_1_1_0_0;
  localparam logic [11:0] V_BR_TK   = 12'b0_10_1_0_0_0_0_1_1_1_0;
  localparam logic [11:0] V_BR_NT   = 12'b0_10_1_0_0_0_0_1_1_0_0;
  localparam logic [11:0] V_ADDI_EX = 12'b0_00_0_1_0_0_0_0_1_0_0;
  localparam logic [11:0] V_ADDI_WB = 12'b0_00_0_1_1_1_0_1_1_0_0;
  localparam logic [11:0] V_HALT    = 12'b0_00_0_0_0_0_0_0_1_0_1;

  logic        CLK;
  logic        reset;
  logic        halted;
  logic [31:0] retired;
  int          checks;
  int          failures;
  logic [11:0] exp_q[$];

  control_unit_if cu_if ();

  control_unit #(.CNT_W(32)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .bus     (cu_if),
    .halted  (halted),
    .retired (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ctl();
    return {cu_if.load_ir, cu_if.imm_sel, cu_if.sub, cu_if.ULA_din2_sel, cu_if.RF_din_sel,
            cu_if.WE_RF, cu_if.WE_MEM, cu_if.load_pc, cu_if.reset_pc, cu_if.pc_next_sel, halted};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Called #1 after the edge with reset still high; ends in FETCH.
  task automatic release_to_fetch(input string tag);
    reset = 1'b0;
    #1;
    check_eq({tag, "_init"}, 64'(ctl()), 64'(V_RST));
    step();
    check_eq({tag, "_fetch"}, 64'(ctl()), 64'(V_FETCH));
  endtask

  // Starts in FETCH; walks exp_q cycle by cycle, scrambles instr after DECODE,
  // then expects the next FETCH and the retired count.
  task automatic run_seq(input string tag, input logic [31:0] ins, input logic z,
                         input logic [31:0] exp_ret);
    cu_if.instr = ins;
    cu_if.zero  = z;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 2) cu_if.instr = 32'h0000_0000;
      #1;
      check_eq($sformatf("%s_c%0d", tag, i), 64'(ctl()), 64'(exp_q[i]));
      step();
    end
    check_eq({tag, "_next_fetch"}, 64'(ctl()), 64'(V_FETCH));
    check_eq({tag, "_retired"}, 64'(retired), 64'(exp_ret));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    cu_if.instr = 32'h0;
    cu_if.zero  = 1'b0;

    step();
    step();
    check_eq("rst_ctl", 64'(ctl()), 64'(V_RST));
    check_eq("rst_retired", 64'(retired), 64'd0);
    release_to_fetch("boot");
    check_eq("boot_retired", 64'(retired), 64'd0);

    exp_q = '{V_FETCH, V_DEC, V_LD_EX, V_LD_EX, V_LD_WB};
    run_seq("ld", 32'h0000_3083, 1'b0, 32'd1);

    exp_q = '{V_FETCH, V_DEC, V_SUB_EX, V_SUB_WB};
    run_seq("sub", 32'h4020_81B3, 1'b0, 32'd2);

    exp_q = '{V_FETCH, V_DEC, V_SD_EX, V_SD_MEM};
    run_seq("sd", 32'h0030_3423, 1'b0, 32'd3);

    exp_q = '{V_FETCH, V_DEC, V_BR_TK};
    run_seq("bne_z0", 32'h0020_9463, 1'b0, 32'd4);

    exp_q = '{V_FETCH, V_DEC, V_BR_NT};
    run_seq("bne_z1", 32'h0020_9463, 1'b1, 32'd5);

    exp_q = '{V_FETCH, V_DEC, V_BR_TK};
    run_seq("beq_z1", 32'h0020_8463, 1'b1, 32'd6);

    // Reset lands during MEM of a store.
    cu_if.instr = 32'h0030_3423;
    cu_if.zero  = 1'b0;
    #1;
    check_eq("rstmem_fetch", 64'(ctl()), 64'(V_FETCH));
    step();
    check_eq("rstmem_dec", 64'(ctl()), 64'(V_DEC));
    step();
    check_eq("rstmem_exec", 64'(ctl()), 64'(V_SD_EX));
    step();
    reset = 1'b1;
    #1;
    check_eq("rstmem_in_mem", 64'(ctl()), 64'(V_RST));
    step();
    check_eq("rstmem_after", 64'(ctl()), 64'(V_RST));
    check_eq("rstmem_retired", 64'(retired), 64'd0);
    release_to_fetch("rstmem");

    exp_q = '{V_FETCH, V_DEC, V_ADDI_EX, V_ADDI_WB};
    run_seq("addi", 32'h0010_8093, 1'b0, 32'd1);

    // Illegal opcode: sticky halt, no enables, counter frozen.
    cu_if.instr = 32'h0000_0000;
    #1;
    check_eq("ill_fetch", 64'(ctl()), 64'(V_FETCH));
    step();
    check_eq("ill_dec", 64'(ctl()), 64'(V_DEC));
    step();
    cu_if.instr = 32'h0000_3083;
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("halt_c%0d", i), 64'(ctl()), 64'(V_HALT));
      check_eq($sformatf("halt_ret_c%0d", i), 64'(retired), 64'd1);
      step();
    end

    reset = 1'b1;
    step();
    check_eq("unhalt_ctl", 64'(ctl()), 64'(V_RST));
    check_eq("unhalt_retired", 64'(retired), 64'd0);
    release_to_fetch("unhalt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM for the RV64 load-store datapath. It sits directly upstream of `datapath`. It reads the instruction register contents and the ULA zero flag, and drives every datapath control input (`sub`, `ULA_din2_sel`, `RF_din_sel`, `WE_RF`, `WE_MEM`, `load_pc`, `reset_pc`, `pc_next_sel`), plus IR load and immediate-format select. This replaces hand-driven control in the datapath benches. It also keeps a retired-instruction counter and a sticky halt on illegal opcodes.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `CLK` input 1: single clock, rising edge. Reset is synchronous and active-high.
- `reset` input 1: synchronous, active-high reset.
- `instr` input 32: instruction register output from the datapath.
- `zero` input 1: ULA result == 0, combinational from the datapath.
- `load_ir` output 1: load IR from instruction memory at the next edge.
- `imm_sel` output 2: immediate format. 00 = I, 01 = S, 10 = B.
- `sub` output 1: ULA subtract.
- `ULA_din2_sel` output 1: 1 = immediate, 0 = rs2.
- `RF_din_sel` output 1: 1 = ULA result, 0 = memory data.
- `WE_RF` output 1: register-file write enable.
- `WE_MEM` output 1: data-memory write enable.
- `load_pc` output 1: PC update enable.
- `reset_pc` output 1: active-low PC clear, as the datapath expects.
- `pc_next_sel` output 1: 1 = PC + branch offset, 0 = PC + 4.
- `halted` output 1: sticky; high after an illegal instruction.
- `retired` output `CNT_W`: count of completed instructions.

## Operation
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are Moore. They decode from the state and from class flags latched in DECODE. The only exception is `pc_next_sel`, which uses `zero` in EXEC of a branch.
- Instruction classes, decoded from `instr[6:0]`, `instr[14:12]` and `instr[30]`:
  - LOAD: 0000011, any funct3.
  - STORE: 0100011.
  - OP: 0110011 with funct3 = 000. `instr[30]` selects add (0) or sub (1).
  - OPIMM: 0010011 with funct3 = 000 (addi).
  - BRANCH: 1100011 with funct3 000 (beq) or 001 (bne).
  - Everything else is ILLEGAL.
- INIT: `reset_pc` = 0, all enables 0. Goes to FETCH.
- FETCH: `load_ir` = 1. Goes to DECODE.
- DECODE: latches class, `is_sub` and `is_bne`. ILLEGAL goes to HALT; all other classes go to EXEC.
- EXEC:
  - `ULA_din2_sel` = 1 for LOAD, STORE and OPIMM; 0 for OP and BRANCH.
  - `sub` = `is_sub` for OP, 1 for BRANCH, 0 otherwise.
  - BRANCH: asserts `load_pc`, with `pc_next_sel` = `zero` XOR `is_bne`, then goes to FETCH (instruction retires).
  - LOAD and STORE go to MEM. OP and OPIMM go to WB.
- MEM:
  - Holds the EXEC ULA controls.
  - STORE: `WE_MEM` = 1, `load_pc` = 1, `pc_next_sel` = 0, then goes to FETCH (retires).
  - LOAD: goes to WB.
- WB:
  - Holds the ULA controls.
  - `WE_RF` = 1, `RF_din_sel` = 0 for LOAD and 1 otherwise.
  - `load_pc` = 1, `pc_next_sel` = 0, then goes to FETCH (retires).
- HALT: all enables 0, `halted` = 1. The state is absorbing until `reset`.
- `imm_sel`: S for STORE, B for BRANCH, I otherwise. It is valid from EXEC through the final state.
- `retired` increments by 1 on the clock edge that leaves a retiring state. It wraps modulo 2^`CNT_W`.
- Register x0 writes are suppressed by the datapath; rd is not checked here.

## Timing
- Reset values (in the reset cycle and the cycle after):
  - State = INIT.
  - `reset_pc` = 0.
  - `load_ir`, `WE_RF`, `WE_MEM`, `load_pc`, `sub`, `pc_next_sel`, `halted` = 0.
  - `retired` = 0.
- First FETCH is the second cycle after `reset` falls.
- Cycles per instruction, FETCH to last state inclusive:
  - BRANCH: 3.
  - STORE, OP, OPIMM: 4.
  - LOAD: 5.
- `WE_RF`, `WE_MEM` and `load_pc` are each high for exactly one cycle per instruction. Branches never assert `WE_RF` or `WE_MEM`.
- `instr` is sampled only in DECODE. Later changes to `instr` have no effect.
- Reset asserted mid-instruction: at the next edge, go to INIT and clear `retired` and `halted`. No write enable is asserted in that cycle.

## Structure
- `control_pkg` holds the state encoding, the opcode/funct3 constants, the `imm_sel` codes and the class enum.
- Sub-module `instr_decoder` is purely combinational. It maps `instr` to class, `is_sub` and `is_bne`. The FSM and counter stay in `control_unit`.

## Test plan
- Reset held 2 cycles, then released:
  - `reset_pc` = 0 through INIT.
  - FETCH (`load_ir` = 1) on the 2nd cycle after release.
  - `retired` = 0.
- `instr` = 0x00003083 (ld x1,0(x0)):
  - 5-cycle sequence.
  - WB has `WE_RF` = 1, `RF_din_sel` = 0, `ULA_din2_sel` = 1, `load_pc` = 1.
  - `retired` = 1.
- `instr` = 0x402081B3 (sub x3,x1,x2):
  - EXEC/WB have `sub` = 1, `ULA_din2_sel` = 0.
  - WB has `RF_din_sel` = 1.
  - 4 cycles total.
- `instr` = 0x00303423 (sd x3,8(x0)):
  - MEM has `WE_MEM` = 1, `imm_sel` = 01, `WE_RF` = 0.
  - 4 cycles total.
- `instr` = 0x00209463 (bne x1,x2,8):
  - With `zero` = 0 in EXEC: `pc_next_sel` = 1, `load_pc` = 1.
  - With `zero` = 1: `pc_next_sel` = 0.
  - `imm_sel` = 10; 3 cycles.
- Illegal and mid-instruction reset:
  - `instr` = 0x00000000: HALT, `halted` = 1, no enables for 10 cycles, `retired` unchanged.
  - `reset` during MEM of a store: `WE_MEM` never asserted, next state INIT.
